// File: rtl/snitch_clint_pkg.sv
// Shared offsets, FSM state and request/response types for snitch_clint.
package snitch_clint_pkg;

    localparam logic [31:0] MsipBase     = 32'h0000_0000;
    localparam logic [31:0] MtimecmpBase = 32'h0000_4000;
    localparam logic [31:0] MtimeLo      = 32'h0000_BFF8;
    localparam logic [31:0] MtimeHi      = 32'h0000_BFFC;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } clint_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } clint_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
    } clint_rsp_t;

    // Replace the strobed bytes of a 32-bit word with write data.
    function automatic logic [31:0] merge_wstrb(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/snitch_clint_rtc_sync.sv
// Two-flop synchronizer plus registered rising-edge detect for an asynchronous
// RTC input; instantiated by snitch_clint only when SNITCH_CLINT_RTC_SYNC_EN is defined.
module snitch_clint_rtc_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rtc_i,
    output logic tick_o
);

    logic [1:0] sync_q, sync_d;
    logic       prev_q, prev_d;
    logic       tick_q, tick_d;

    always_comb begin
        sync_d = {sync_q[0], rtc_i};
        prev_d = sync_q[1];
        tick_d = sync_q[1] & ~prev_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/snitch_clint.sv
// Core-local interruptor: per-core msip bits, free-running 64-bit mtime and per-core
// mtimecmp behind a single-outstanding register port. SNITCH_CLINT_RTC_SYNC_EN selects an async rtc_i.
module snitch_clint
    import snitch_clint_pkg::*;
#(
    parameter int unsigned NrCores   = 8,
    parameter int unsigned AddrWidth = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rtc_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic                 req_write_i,
    input  logic [31:0]          req_wdata_i,
    input  logic [3:0]           req_wstrb_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [31:0]          rsp_rdata_o,
    output logic                 rsp_error_o,
    output logic [NrCores-1:0]   msip_o,
    output logic [NrCores-1:0]   mtip_o
);

    localparam int unsigned IdxWidth = (NrCores > 1) ? $clog2(NrCores) : 1;

    clint_state_e        state_q, state_d;
    clint_req_t          req;
    clint_rsp_t          rsp_q, rsp_d, rsp_now;
    logic [NrCores-1:0]  msip_q, msip_d;
    logic [NrCores-1:0]  mtip_q, mtip_d;
    logic [63:0]         mtime_q, mtime_d;
    logic [63:0]         mtimecmp_q [NrCores];
    logic [63:0]         mtimecmp_d [NrCores];
    logic                tick;
    logic                accept;
    logic                hit_msip, hit_cmp, hit_mtime_lo, hit_mtime_hi, cmp_hi;
    logic [31:0]         msip_off, cmp_off;
    logic [IdxWidth-1:0] idx;

`ifdef SNITCH_CLINT_RTC_SYNC_EN
    snitch_clint_rtc_sync i_rtc_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .rtc_i  (rtc_i),
        .tick_o (tick)
    );
`else
    assign tick = rtc_i;
`endif

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        req       = '0;
        req.addr  = 32'(req_addr_i) & ~32'h3;
        req.write = req_write_i;
        req.wdata = req_wdata_i;
        req.wstrb = req_wstrb_i;
    end

    assign accept = req_valid_i && (state_q == IDLE);

    // Offsets below a window's base wrap to large values and fall outside it.
    always_comb begin
        msip_off     = req.addr - MsipBase;
        cmp_off      = req.addr - MtimecmpBase;
        hit_msip     = msip_off < 32'(4 * NrCores);
        hit_cmp      = cmp_off < 32'(8 * NrCores);
        hit_mtime_lo = req.addr == MtimeLo;
        hit_mtime_hi = req.addr == MtimeHi;
        cmp_hi       = cmp_off[2];
        idx          = hit_msip ? IdxWidth'(msip_off >> 2) : IdxWidth'(cmp_off >> 3);
    end

    always_comb begin
        rsp_now = '0;
        if (hit_msip) begin
            rsp_now.rdata = {31'd0, msip_q[idx]};
        end else if (hit_cmp) begin
            rsp_now.rdata = cmp_hi ? mtimecmp_q[idx][63:32] : mtimecmp_q[idx][31:0];
        end else if (hit_mtime_lo) begin
            rsp_now.rdata = mtime_q[31:0];
        end else if (hit_mtime_hi) begin
            rsp_now.rdata = mtime_q[63:32];
        end else begin
            rsp_now.error = 1'b1;
        end
        if (req.write) rsp_now.rdata = '0;
        rsp_d = accept ? rsp_now : rsp_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req_valid_i) state_d = RESP;
            RESP: if (rsp_ready_i) state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = (state_q == IDLE);
        rsp_valid_o = (state_q == RESP);
    end

    // A written mtime half overrides that half's tick; the other half keeps the increment.
    always_comb begin
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        mtime_d    = mtime_q + 64'(tick);
        if (accept && req.write) begin
            if (hit_msip && req.wstrb[0]) msip_d[idx] = req.wdata[0];
            if (hit_cmp) begin
                if (cmp_hi) begin
                    mtimecmp_d[idx][63:32] = merge_wstrb(mtimecmp_q[idx][63:32], req.wdata, req.wstrb);
                end else begin
                    mtimecmp_d[idx][31:0] = merge_wstrb(mtimecmp_q[idx][31:0], req.wdata, req.wstrb);
                end
            end
            if (hit_mtime_lo) mtime_d[31:0]  = merge_wstrb(mtime_q[31:0], req.wdata, req.wstrb);
            if (hit_mtime_hi) mtime_d[63:32] = merge_wstrb(mtime_q[63:32], req.wdata, req.wstrb);
        end
    end

    always_comb begin
        mtip_d = '0;
        for (int i = 0; i < int'(NrCores); i++) begin
            mtip_d[i] = mtime_q >= mtimecmp_q[i];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rsp_q   <= '0;
            msip_q  <= '0;
            mtip_q  <= '0;
            mtime_q <= '0;
            // NOTE: the compare array is reset because its all-ones value is
            // architecturally visible and keeps mtip low after reset.
            for (int i = 0; i < int'(NrCores); i++) begin
                mtimecmp_q[i] <= '1;
            end
        end else begin
            state_q    <= state_d;
            rsp_q      <= rsp_d;
            msip_q     <= msip_d;
            mtip_q     <= mtip_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
        end
    end

    assign rsp_rdata_o = rsp_q.rdata;
    assign rsp_error_o = rsp_q.error;
    assign msip_o      = msip_q;
    assign mtip_o      = mtip_q;

endmodule

// File: tb/tb_snitch_clint.sv
// Self-checking bench for snitch_clint (default build, rtc_i as a synchronous enable)
// against a word-level register-map model.
module tb_snitch_clint;

    localparam int unsigned NrCores = 8;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               rtc_i;
    logic               req_valid_i;
    logic               req_ready_o;
    logic [15:0]        req_addr_i;
    logic               req_write_i;
    logic [31:0]        req_wdata_i;
    logic [3:0]         req_wstrb_i;
    logic               rsp_valid_o;
    logic               rsp_ready_i;
    logic [31:0]        rsp_rdata_o;
    logic               rsp_error_o;
    logic [NrCores-1:0] msip_o;
    logic [NrCores-1:0] mtip_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0]        m_mtime;
    logic [63:0]        m_cmp [NrCores];
    logic [NrCores-1:0] m_msip;
    logic [31:0]        erd;
    logic               eer;
    logic [NrCores-1:0] emtip;
    logic [15:0]        ra;

    snitch_clint #(.NrCores(NrCores), .AddrWidth(16)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rtc_i       (rtc_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_write_i (req_write_i),
        .req_wdata_i (req_wdata_i),
        .req_wstrb_i (req_wstrb_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_error_o (rsp_error_o),
        .msip_o      (msip_o),
        .mtip_o      (mtip_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bytes_merge(input logic [31:0] w, input logic [31:0] d,
                                                input logic [3:0] s);
        logic [31:0] r;
        r = w;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [NrCores-1:0] exp_mtip();
        logic [NrCores-1:0] r;
        for (int i = 0; i < int'(NrCores); i++) r[i] = m_mtime >= m_cmp[i];
        return r;
    endfunction

    task automatic model_reset();
        m_mtime = 64'd0;
        m_msip  = '0;
        for (int i = 0; i < int'(NrCores); i++) m_cmp[i] = '1;
    endtask

    // Register-map semantics: returns the pre-edge read value, then applies the write/tick.
    task automatic model_access(input logic [15:0] addr, input logic wr, input logic [31:0] wd,
                                input logic [3:0] ws, input logic tk,
                                output logic [31:0] rd, output logic er);
        int unsigned off, core;
        logic [63:0] nxt;
        logic [31:0] word;
        logic        hi;
        off = {16'd0, addr} & 32'hFFFC;
        nxt = m_mtime + (tk ? 64'd1 : 64'd0);
        rd  = '0;
        er  = 1'b0;
        hi  = (off % 8) == 4;
        if (off < 4 * NrCores) begin
            core = off / 4;
            if (!wr) rd = {31'd0, m_msip[core]};
            else if (ws[0]) m_msip[core] = wd[0];
            m_mtime = nxt;
        end else if (off >= 32'h4000 && off < 32'h4000 + 8 * NrCores) begin
            core = (off - 32'h4000) / 8;
            word = hi ? m_cmp[core][63:32] : m_cmp[core][31:0];
            if (!wr) rd = word;
            else begin
                word = bytes_merge(word, wd, ws);
                if (hi) m_cmp[core][63:32] = word;
                else    m_cmp[core][31:0]  = word;
            end
            m_mtime = nxt;
        end else if (off == 32'hBFF8 || off == 32'hBFFC) begin
            word = hi ? m_mtime[63:32] : m_mtime[31:0];
            if (!wr) rd = word;
            m_mtime = nxt;
            if (wr) begin
                word = bytes_merge(word, wd, ws);
                if (hi) m_mtime[63:32] = word;
                else    m_mtime[31:0]  = word;
            end
        end else begin
            er = 1'b1;
            m_mtime = nxt;
        end
    endtask

    // One complete transaction with rsp_ready_i held high; tk drives rtc_i in the accept cycle.
    task automatic txn(input logic [15:0] a, input logic wr, input logic [31:0] wd,
                       input logic [3:0] ws, input logic tk, input string tag);
        logic [31:0] xrd;
        logic        xer;
        int          cyc;
        model_access(a, wr, wd, ws, tk, xrd, xer);
        check({tag, "/req_ready"}, 64'(req_ready_o), 64'd1);
        req_valid_i = 1'b1;
        req_addr_i  = a;
        req_write_i = wr;
        req_wdata_i = wd;
        req_wstrb_i = ws;
        rtc_i       = tk;
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        rtc_i       = 1'b0;
        check({tag, "/msip"}, 64'(msip_o), 64'(m_msip));
        cyc = 0;
        while (!rsp_valid_o && cyc < 8) begin
            @(posedge clk_i); #1;
            cyc++;
        end
        check({tag, "/rsp_valid"}, 64'(rsp_valid_o), 64'd1);
        check({tag, "/rdata"}, 64'(rsp_rdata_o), 64'(xrd));
        check({tag, "/error"}, 64'(rsp_error_o), 64'(xer));
        @(posedge clk_i); #1;
        check({tag, "/rsp_done"}, 64'(rsp_valid_o), 64'd0);
        check({tag, "/mtip"}, 64'(mtip_o), 64'(exp_mtip()));
    endtask

    initial begin
        rst_i       = 1'b1;
        rtc_i       = 1'b0;
        req_valid_i = 1'b0;
        req_addr_i  = '0;
        req_write_i = 1'b0;
        req_wdata_i = '0;
        req_wstrb_i = '0;
        rsp_ready_i = 1'b1;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        check("rst/req_ready", 64'(req_ready_o), 64'd1);
        check("rst/rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("rst/rdata", 64'(rsp_rdata_o), 64'd0);
        check("rst/error", 64'(rsp_error_o), 64'd0);
        check("rst/msip", 64'(msip_o), 64'd0);
        check("rst/mtip", 64'(mtip_o), 64'd0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        txn(16'hBFF8, 1'b0, 32'd0, 4'h0, 1'b0, "rst_mtime");
        txn(16'h4000, 1'b0, 32'd0, 4'h0, 1'b0, "rst_cmp0");

        // Software interrupt set, clear and read back.
        txn(16'h0004, 1'b1, 32'd1, 4'hF, 1'b0, "msip1_set");
        check("msip1_bit", 64'(msip_o[1]), 64'd1);
        txn(16'h0004, 1'b1, 32'd0, 4'hF, 1'b0, "msip1_clr");
        txn(16'h0004, 1'b0, 32'd0, 4'h0, 1'b0, "msip1_rd");

        // Timer interrupt for core 0 with rtc_i held high.
        txn(16'h4000, 1'b1, 32'd10, 4'hF, 1'b0, "cmp0_lo");
        txn(16'h4004, 1'b1, 32'd0, 4'hF, 1'b0, "cmp0_hi");
        rtc_i = 1'b1;
        for (int c = 0; c < 14; c++) begin
            emtip = exp_mtip();
            @(posedge clk_i); #1;
            m_mtime = m_mtime + 64'd1;
            check("timer/mtip", 64'(mtip_o), 64'(emtip));
        end
        rtc_i = 1'b0;
        check("timer/mtip0_high", 64'(mtip_o[0]), 64'd1);

        // Wrap-around of mtime.
        txn(16'hBFFC, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b0, "wrap_hi");
        txn(16'hBFF8, 1'b1, 32'hFFFF_FFFE, 4'hF, 1'b0, "wrap_lo");
        rtc_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rtc_i = 1'b0;
        m_mtime = m_mtime + 64'd2;
        txn(16'hBFF8, 1'b0, 32'd0, 4'h0, 1'b0, "wrap_rd_lo");
        txn(16'hBFFC, 1'b0, 32'd0, 4'h0, 1'b0, "wrap_rd_hi");

        // Write and tick in the same cycle; partial half write keeps the other half's increment.
        txn(16'hBFF8, 1'b1, 32'h0000_1234, 4'hF, 1'b1, "wtick_lo");
        txn(16'hBFF8, 1'b0, 32'd0, 4'h0, 1'b0, "wtick_rd_lo");
        txn(16'hBFF8, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b0, "carry_lo");
        txn(16'hBFFC, 1'b1, 32'd5, 4'hF, 1'b1, "wtick_hi");
        txn(16'hBFF8, 1'b0, 32'd0, 4'h0, 1'b0, "wtick_rd_lo2");
        txn(16'hBFFC, 1'b0, 32'd0, 4'h0, 1'b0, "wtick_rd_hi2");

        // Byte strobes and unmapped offsets.
        txn(16'h4008, 1'b1, 32'hAABB_CCDD, 4'b0101, 1'b0, "strb_cmp1");
        txn(16'h4008, 1'b0, 32'd0, 4'h0, 1'b0, "strb_cmp1_rd");
        txn(16'h8000, 1'b0, 32'd0, 4'h0, 1'b0, "unmapped_rd");
        txn(16'h0020, 1'b1, 32'd1, 4'hF, 1'b0, "msip8_wr");
        txn(16'h4040, 1'b1, 32'd0, 4'hF, 1'b0, "cmp8_wr");

        // Back-pressure: response held for 5 cycles while a second request waits.
        model_access(16'h4008, 1'b0, 32'd0, 4'h0, 1'b0, erd, eer);
        req_valid_i = 1'b1;
        req_addr_i  = 16'h4008;
        req_write_i = 1'b0;
        rsp_ready_i = 1'b0;
        @(posedge clk_i); #1;
        req_addr_i  = 16'h0000;
        req_write_i = 1'b1;
        req_wdata_i = 32'd1;
        req_wstrb_i = 4'hF;
        for (int c = 0; c < 5; c++) begin
            check("hs/rsp_valid", 64'(rsp_valid_o), 64'd1);
            check("hs/req_ready", 64'(req_ready_o), 64'd0);
            check("hs/rdata", 64'(rsp_rdata_o), 64'(erd));
            check("hs/error", 64'(rsp_error_o), 64'(eer));
            check("hs/msip", 64'(msip_o), 64'(m_msip));
            @(posedge clk_i); #1;
        end
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        check("hs/release", 64'(rsp_valid_o), 64'd0);
        check("hs/no_accept", 64'(msip_o), 64'(m_msip));

        // Randomised traffic over mapped, unmapped and misaligned offsets.
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 12))
                0:  ra = 16'h0000;
                1:  ra = 16'h0004;
                2:  ra = 16'h001C;
                3:  ra = 16'h0020;
                4:  ra = 16'h4000;
                5:  ra = 16'h4004;
                6:  ra = 16'h4038;
                7:  ra = 16'h403C;
                8:  ra = 16'h4040;
                9:  ra = 16'hBFF8;
                10: ra = 16'hBFFC;
                11: ra = 16'h8000;
                default: ra = 16'($urandom);
            endcase
            ra = ra | 16'($urandom_range(0, 3));
            txn(ra, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), 1'($urandom_range(0, 1)), "rand");
        end

        // Reset while a response is pending.
        txn(16'h4000, 1'b1, 32'd0, 4'hF, 1'b0, "pre_rst_cmp0");
        model_access(16'h0008, 1'b1, 32'd1, 4'hF, 1'b0, erd, eer);
        req_valid_i = 1'b1;
        req_addr_i  = 16'h0008;
        req_write_i = 1'b1;
        req_wdata_i = 32'd1;
        req_wstrb_i = 4'hF;
        rsp_ready_i = 1'b0;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        check("midrst/msip_set", 64'(msip_o), 64'(m_msip));
        check("midrst/pending", 64'(rsp_valid_o), 64'd1);
        rst_i = 1'b1;
        #1;
        model_reset();
        check("midrst/rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("midrst/req_ready", 64'(req_ready_o), 64'd1);
        check("midrst/msip", 64'(msip_o), 64'd0);
        check("midrst/mtip", 64'(mtip_o), 64'd0);
        @(posedge clk_i); #1;
        rst_i       = 1'b0;
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        txn(16'h4000, 1'b0, 32'd0, 4'h0, 1'b0, "post_rst_cmp0");
        txn(16'hBFF8, 1'b0, 32'd0, 4'h0, 1'b0, "post_rst_mtime");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
